// File: rtl/uart_pkg.sv
// Shared types and constants for the 8-E-1 UART receiver.
// Holds the FSM state enum and the even-parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  function automatic logic even_par(
    input logic [DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw RX pin, reset to idle-high.
// Only built when UART_RX_INPUT_SYNC_EN is defined.
`ifdef UART_RX_INPUT_SYNC_EN
module uart_rx_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  assign sync_d = {sync_q[0], d_i};
  assign q_o    = sync_q[1];

  // Shift the pin through two flops; idle level after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

endmodule
`endif

// File: rtl/uart_rx.sv
// 8-E-1 UART receiver with parity and stop/framing flags.
// UART_RX_INPUT_SYNC_EN adds a 2-flop input synchroniser.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 1,
  parameter int SAMPLE_OFFSET = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_data_in,
  output logic [7:0] rx_data_out,
  output logic       parity_error,
  output logic       stop_error
);

  localparam int BAUD_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT + 1) : 1;

  // Reload values: the counter counts down to the next sample.
  localparam logic [BAUD_W-1:0] BAUD_LAST =
    BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] OFF_LAST =
    BAUD_W'((SAMPLE_OFFSET > 0) ? SAMPLE_OFFSET - 1 : 0);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic rx_s;

`ifdef UART_RX_INPUT_SYNC_EN
  uart_rx_sync u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (rx_data_in),
    .q_o     (rx_s)
  );
`else
  assign rx_s = rx_data_in;
`endif

  rx_state_e             state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  armed_q, armed_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic                  sample;

  assign sample       = (baud_q == '0);
  assign rx_data_out  = data_q;
  assign parity_error = perr_q;
  assign stop_error   = serr_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      armed_q <= 1'b1;
      data_q  <= '0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      serr_q  <= serr_d;
    end
  end

  // Next-state: advance one phase per sample point.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (armed_q && !rx_s) begin
          state_d = (SAMPLE_OFFSET == 0) ? DATA : START;
        end
      end
      START: begin
        if (sample) begin
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample && bit_q == LAST_BIT) begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        if (sample) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: counters, shift register, completion registers.
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    armed_d = armed_q;
    data_d  = data_q;
    perr_d  = perr_q;
    serr_d  = serr_q;
    if (!sample) begin
      baud_d = baud_q - 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          baud_d = (SAMPLE_OFFSET == 0) ? BAUD_LAST : OFF_LAST;
        end
      end
      START: begin
        if (sample) begin
          baud_d = rx_s ? '0 : BAUD_LAST;
        end
      end
      DATA: begin
        if (sample) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          baud_d  = BAUD_LAST;
        end
      end
      PARITY: begin
        if (sample) begin
          par_d  = rx_s;
          baud_d = BAUD_LAST;
        end
      end
      STOP: begin
        if (sample) begin
          data_d  = shift_q;
          perr_d  = even_par(shift_q) ^ par_q;
          serr_d  = (rx_s != STOP_LEVEL);
          // A low stop bit may be a break: wait for high first.
          armed_d = (rx_s == STOP_LEVEL);
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      default: begin
        baud_d = '0;
        bit_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT 1 and 4).
// Random frames are checked against a byte-level model.
module tb_uart_rx;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] d1, d4;
  logic       p1, p4, s1, s4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] exp_data = 8'h00;
  logic       exp_perr = 1'b0;
  logic       exp_serr = 1'b0;

`ifdef UART_RX_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data_in   (rx),
    .rx_data_out  (d1),
    .parity_error (p1),
    .stop_error   (s1)
  );

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .rx_data_in   (rx),
    .rx_data_out  (d4),
    .parity_error (p4),
    .stop_error   (s4)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_data = 8'h00;
    exp_perr = 1'b0;
    exp_serr = 1'b0;
  endtask

  // Drive one frame; check hold before stop, result after.
  task automatic send_frame(input int cpb, input logic [7:0] b,
                            input logic pbit, input logic sbit,
                            input string tag);
    logic [10:0] bits;
    logic [7:0]  od;
    logic        op, os;
    bits = {sbit, pbit, b, 1'b0};
    for (int k = 0; k < 11; k++) begin
      rx = bits[k];
      if (k == 10) begin
        od = (cpb == 1) ? d1 : d4;
        op = (cpb == 1) ? p1 : p4;
        os = (cpb == 1) ? s1 : s4;
        total_cnt++;
        if (od !== exp_data || op !== exp_perr || os !== exp_serr)
          $display("FAIL %s_hold: got %h/%b/%b want %h/%b/%b",
                   tag, od, op, os, exp_data, exp_perr, exp_serr);
        else pass_cnt++;
      end
      repeat (cpb) @(negedge clk);
    end
    repeat (LAT) @(negedge clk);
    exp_data = b;
    exp_perr = ($countones({b, pbit}) % 2) == 1;
    exp_serr = (sbit == 1'b0);
    od = (cpb == 1) ? d1 : d4;
    op = (cpb == 1) ? p1 : p4;
    os = (cpb == 1) ? s1 : s4;
    total_cnt++;
    if (od !== exp_data || op !== exp_perr || os !== exp_serr)
      $display("FAIL %s_done: got %h/%b/%b want %h/%b/%b",
               tag, od, op, os, exp_data, exp_perr, exp_serr);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    #50;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (d1 !== 8'h00 || p1 !== 1'b0 || s1 !== 1'b0)
      $display("FAIL reset1: got %h/%b/%b want 00/0/0", d1, p1, s1);
    else pass_cnt++;
    total_cnt++;
    if (d4 !== 8'h00 || p4 !== 1'b0 || s4 !== 1'b0)
      $display("FAIL reset4: got %h/%b/%b want 00/0/0", d4, p4, s4);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    send_frame(1, 8'hAD, 1'b1, 1'b1, "basic_ad");
  endtask

  task automatic test_idle_gaps();
    send_frame(1, 8'h3C, 1'b0, 1'b1, "gap_3c");
    rx = 1'b1;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (d1 !== 8'h3C || p1 !== 1'b0 || s1 !== 1'b0)
      $display("FAIL gap_hold: got %h/%b/%b want 3c/0/0", d1, p1, s1);
    else pass_cnt++;
    send_frame(1, 8'hE1, 1'b0, 1'b1, "gap_e1");
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_parity();
    send_frame(1, 8'h3C, 1'b1, 1'b1, "par_bad");
    rx = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(1, 8'hAD, 1'b1, 1'b1, "par_clear");
    rx = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_break();
    send_frame(1, 8'hE1, 1'b0, 1'b0, "brk_stop");
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (15) @(negedge clk);
    total_cnt++;
    if (d1 !== 8'hE1 || p1 !== 1'b0 || s1 !== 1'b1)
      $display("FAIL brk_quiet: got %h/%b/%b want e1/0/1", d1, p1, s1);
    else pass_cnt++;
    send_frame(1, 8'h3C, 1'b0, 1'b1, "brk_clear");
    rx = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [4:0] part;
    do_reset();
    part = {4'hD, 1'b0};
    for (int k = 0; k < 5; k++) begin
      rx = part[k];
      @(negedge clk);
    end
    do_reset();
    repeat (15) @(negedge clk);
    total_cnt++;
    if (d1 !== 8'h00 || p1 !== 1'b0 || s1 !== 1'b0)
      $display("FAIL abort: got %h/%b/%b want 00/0/0", d1, p1, s1);
    else pass_cnt++;
    send_frame(1, 8'h3C, 1'b0, 1'b1, "abort_next");
    rx = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       flip;
    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom);
      flip = 1'($urandom_range(0, 3) == 0);
      send_frame(1, b, (^b) ^ flip, 1'b1, "rand1");
      rx = 1'b1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_cpb4();
    logic [7:0] b;
    do_reset();
    total_cnt++;
    if (d4 !== 8'h00 || p4 !== 1'b0 || s4 !== 1'b0)
      $display("FAIL c4_reset: got %h/%b/%b want 00/0/0", d4, p4, s4);
    else pass_cnt++;
    send_frame(4, 8'hAD, 1'b1, 1'b1, "c4_ad");
    send_frame(4, 8'h3C, 1'b0, 1'b1, "c4_3c");
    rx = 1'b1;
    repeat (8) @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    total_cnt++;
    if (d4 !== 8'h3C || p4 !== 1'b0 || s4 !== 1'b0)
      $display("FAIL c4_glitch: got %h/%b/%b want 3c/0/0", d4, p4, s4);
    else pass_cnt++;
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      send_frame(4, b, (^b) ^ 1'($urandom_range(0, 1)), 1'b1, "rand4");
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_gaps();
    test_parity();
    test_break();
    test_reset_midframe();
    test_random();
    test_cpb4();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
